// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcodes and the EX-stage
// control word carried alongside the operands.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int RN   = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [3:0] ALU_SLT = 4'b1011;

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic [RN-1:0] wn;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ID/EX boundary bus: decoded instruction and forwarding candidates in,
// registered EX operands/control and the load-use stall out.
interface ex_issue_stage_if #(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int RN   = pipe_pkg::RN
);
  logic            id_valid;
  logic [3:0]      id_aluc;
  logic [RN-1:0]   id_rs;
  logic [RN-1:0]   id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [XLEN-1:0] id_qa;
  logic [XLEN-1:0] id_qb;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_sa;
  logic            id_shift;
  logic            id_aluimm;
  logic            id_wreg;
  logic            id_m2reg;
  logic [RN-1:0]   id_wn;
  logic            flush;
  logic [XLEN-1:0] alu_s;
  logic            mem_wreg;
  logic [RN-1:0]   mem_wn;
  logic [XLEN-1:0] mem_val;
  logic            ex_valid;
  logic            ex_wreg;
  logic            ex_m2reg;
  logic [RN-1:0]   ex_wn;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [3:0]      ex_aluc;
  logic [XLEN-1:0] ex_st_data;
  logic            stall;

  modport master (
    output id_valid, id_aluc, id_rs, id_rt, id_use_rs, id_use_rt, id_qa, id_qb,
           id_imm, id_sa, id_shift, id_aluimm, id_wreg, id_m2reg, id_wn, flush,
           alu_s, mem_wreg, mem_wn, mem_val,
    input  ex_valid, ex_wreg, ex_m2reg, ex_wn, ex_a, ex_b, ex_aluc, ex_st_data, stall
  );

  modport slave (
    input  id_valid, id_aluc, id_rs, id_rt, id_use_rs, id_use_rt, id_qa, id_qb,
           id_imm, id_sa, id_shift, id_aluimm, id_wreg, id_m2reg, id_wn, flush,
           alu_s, mem_wreg, mem_wn, mem_val,
    output ex_valid, ex_wreg, ex_m2reg, ex_wn, ex_a, ex_b, ex_aluc, ex_st_data, stall
  );

endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Per-source operand forwarding. With EX_ISSUE_FWD_EN defined the value comes
// from EX (ALU result), then MEM, then the register file, and ld_hit flags a
// load in EX that the source depends on. Without it the register-file value
// is always used and ld_hit flags any in-flight EX/MEM producer of the source.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int RN   = pipe_pkg::RN
) (
  input  logic [RN-1:0]   r,
  input  logic            use_r,
  input  logic [XLEN-1:0] rf,
  input  ex_ctrl_t        ex_ctrl,
  input  logic [XLEN-1:0] alu_s,
  input  logic            mem_wreg,
  input  logic [RN-1:0]   mem_wn,
  input  logic [XLEN-1:0] mem_val,
  output logic [XLEN-1:0] val,
  output logic            ld_hit
);

  logic live;
  logic ex_match;
  logic mem_match;

  // $0 is hardwired, so it never matches a producer
  assign live      = use_r && (r != '0);
  assign ex_match  = live && ex_ctrl.valid && ex_ctrl.wreg && (ex_ctrl.wn == r);
  assign mem_match = live && mem_wreg && (mem_wn == r);

`ifdef EX_ISSUE_FWD_EN
  // Youngest producer wins; a load in EX has no data yet and stalls instead
  always_comb begin
    val = rf;
    if (ex_match && !ex_ctrl.m2reg) val = alu_s;
    else if (mem_match)             val = mem_val;
  end

  assign ld_hit = ex_match && ex_ctrl.m2reg;
`else
  logic unused_fwd;

  assign val        = rf;
  assign ld_hit     = ex_match || mem_match;
  assign unused_fwd = ^{alu_s, mem_val};
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: selects and forwards ALU operands, registers them with
// writeback control into EX, and raises stall on a data hazard.
// Optional feature macro: EX_ISSUE_FWD_EN (operand forwarding from EX/MEM).
module ex_issue_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int RN   = pipe_pkg::RN
) (
  input logic             clock,
  input logic             reset,
  ex_issue_stage_if.slave bus
);

  ex_ctrl_t        ctrl_p1;
  logic [3:0]      aluc_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [XLEN-1:0] st_p1;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            hit_a;
  logic            hit_b;
  logic            stall_c;
  logic            issue;
  logic [XLEN-1:0] a_nx;
  logic [XLEN-1:0] b_nx;

  fwd_mux #(.XLEN(XLEN), .RN(RN)) u_fwd_a (
    .r        (bus.id_rs),
    .use_r    (bus.id_use_rs),
    .rf       (bus.id_qa),
    .ex_ctrl  (ctrl_p1),
    .alu_s    (bus.alu_s),
    .mem_wreg (bus.mem_wreg),
    .mem_wn   (bus.mem_wn),
    .mem_val  (bus.mem_val),
    .val      (fwd_a),
    .ld_hit   (hit_a)
  );

  fwd_mux #(.XLEN(XLEN), .RN(RN)) u_fwd_b (
    .r        (bus.id_rt),
    .use_r    (bus.id_use_rt),
    .rf       (bus.id_qb),
    .ex_ctrl  (ctrl_p1),
    .alu_s    (bus.alu_s),
    .mem_wreg (bus.mem_wreg),
    .mem_wn   (bus.mem_wn),
    .mem_val  (bus.mem_val),
    .val      (fwd_b),
    .ld_hit   (hit_b)
  );

  // Flush, reset and an empty ID slot all suppress the stall
  assign stall_c = !reset && bus.id_valid && !bus.flush && (hit_a || hit_b);
  assign issue   = bus.id_valid && !bus.flush && !stall_c;

  assign a_nx = bus.id_shift  ? {{(XLEN-5){1'b0}}, bus.id_sa} : fwd_a;
  assign b_nx = bus.id_aluimm ? bus.id_imm : fwd_b;

  // ---- ID -> EX boundary ----
  // Load the issued instruction, or an all-zero bubble when nothing issues
  always_ff @(posedge clock) begin
    if (reset || !issue) begin
      ctrl_p1 <= '0;
      aluc_p1 <= ALU_ADD;
      a_p1    <= '0;
      b_p1    <= '0;
      st_p1   <= '0;
    end else begin
      ctrl_p1 <= '{valid: 1'b1, wreg: bus.id_wreg, m2reg: bus.id_m2reg, wn: bus.id_wn};
      aluc_p1 <= bus.id_aluc;
      a_p1    <= a_nx;
      b_p1    <= b_nx;
      st_p1   <= fwd_b;
    end
  end

  assign bus.ex_valid   = ctrl_p1.valid;
  assign bus.ex_wreg    = ctrl_p1.wreg;
  assign bus.ex_m2reg   = ctrl_p1.m2reg;
  assign bus.ex_wn      = ctrl_p1.wn;
  assign bus.ex_aluc    = aluc_p1;
  assign bus.ex_a       = a_p1;
  assign bus.ex_b       = b_p1;
  assign bus.ex_st_data = st_p1;
  assign bus.stall      = stall_c;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: the driver pushes hand-computed
// expectations (stall for the current cycle, EX contents for the next one);
// a negedge monitor pops and compares them when they fall due.
module tb_ex_issue_stage;
  import pipe_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string        nm;
    int           due;
    bit           is_ex;
    logic [107:0] exp;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [107:0] ex_now();
    return {bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wn, bus.ex_aluc,
            bus.ex_a, bus.ex_b, bus.ex_st_data};
  endfunction

  // Monitor: compare every expectation that has fallen due
  always @(negedge clock) begin
    ent_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++;
        $display("FAIL %s: checked at cycle %0d, required at cycle %0d", e.nm, cyc, e.due);
      end else if (e.is_ex) begin
        if (ex_now() !== e.exp) begin
          failures++;
          $display("FAIL %s: got v/w/m/wn/aluc/a/b/st=%h required %h", e.nm, ex_now(), e.exp);
        end
      end else if (bus.stall !== e.exp[0]) begin
        failures++;
        $display("FAIL %s: stall got %b required %b", e.nm, bus.stall, e.exp[0]);
      end
    end
  end

  task automatic idle_inputs();
    bus.id_valid  = 1'b0; bus.id_aluc   = 4'd0;  bus.id_rs    = 5'd0; bus.id_rt = 5'd0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;  bus.id_qa    = '0;   bus.id_qb = '0;
    bus.id_imm    = '0;   bus.id_sa     = 5'd0;  bus.id_shift = 1'b0; bus.id_aluimm = 1'b0;
    bus.id_wreg   = 1'b0; bus.id_m2reg  = 1'b0;  bus.id_wn    = 5'd0; bus.flush = 1'b0;
    bus.alu_s     = '0;   bus.mem_wreg  = 1'b0;  bus.mem_wn   = 5'd0; bus.mem_val = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic set_id(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [31:0] qa,
                        input logic [31:0] qb, input logic [4:0] wn, input logic w,
                        input logic m);
    bus.id_valid = 1'b1; bus.id_aluc = op; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_use_rs = urs; bus.id_use_rt = urt; bus.id_qa = qa; bus.id_qb = qb;
    bus.id_wn = wn; bus.id_wreg = w; bus.id_m2reg = m;
  endtask

  task automatic push(input string nm, input int off, input bit is_ex, input logic [107:0] v);
    ent_t e;
    e.nm = nm; e.due = cyc + off; e.is_ex = is_ex; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp_s(input string nm, input logic s);
    push(nm, 0, 1'b0, {107'd0, s});
  endtask

  task automatic exp_x(input string nm, input logic v, input logic w, input logic m,
                       input logic [4:0] wn, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] st);
    push(nm, 1, 1'b1, {v, w, m, wn, op, a, b, st});
  endtask

  task automatic exp_bub(input string nm);
    exp_x(nm, 1'b0, 1'b0, 1'b0, 5'd0, ALU_ADD, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic issue_lw6();
    set_id(ALU_ADD, 5'd1, 5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 5'd6, 1'b1, 1'b1);
    bus.id_aluimm = 1'b1; bus.id_imm = 32'h4;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with a real instruction in ID
    reset = 1'b1;
    idle_inputs();
    set_id(ALU_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 32'h5, 32'h6, 5'd1, 1'b1, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b0;
    push("reset_ex", 0, 1'b1, 108'd0);
    exp_s("reset_stall", 1'b0);
    exp_bub("idle0");

`ifdef EX_ISSUE_FWD_EN
    // EX forward: add $3,$1,$2 then sub $4,$3,$5
    tick(); set_id(ALU_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 32'h10, 32'h20, 5'd3, 1'b1, 1'b0);
    exp_s("add_s", 1'b0); exp_x("add_x", 1, 1, 0, 5'd3, ALU_ADD, 32'h10, 32'h20, 32'h20);
    tick(); bus.alu_s = 32'h7;
    set_id(ALU_SUB, 5'd3, 5'd5, 1'b1, 1'b1, 32'hDEAD, 32'h5, 5'd4, 1'b1, 1'b0);
    exp_s("exfwd_s", 1'b0); exp_x("exfwd_x", 1, 1, 0, 5'd4, ALU_SUB, 32'h7, 32'h5, 32'h5);
    tick(); exp_s("idle1_s", 1'b0); exp_bub("idle1_x");
    // MEM forward and EX priority
    tick(); set_id(ALU_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0);
    exp_x("add3_x", 1, 1, 0, 5'd3, ALU_ADD, 32'h1, 32'h2, 32'h2);
    tick(); bus.alu_s = 32'h22; bus.mem_wreg = 1'b1; bus.mem_wn = 5'd3; bus.mem_val = 32'h11;
    set_id(ALU_SUB, 5'd3, 5'd9, 1'b1, 1'b1, 32'hBAD, 32'h9, 5'd8, 1'b1, 1'b0);
    exp_s("prio_s", 1'b0); exp_x("prio_x", 1, 1, 0, 5'd8, ALU_SUB, 32'h22, 32'h9, 32'h9);
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd3; bus.mem_val = 32'h11;
    set_id(ALU_SUB, 5'd3, 5'd9, 1'b1, 1'b1, 32'hBAD, 32'h9, 5'd8, 1'b1, 1'b0);
    exp_s("memfwd_s", 1'b0); exp_x("memfwd_x", 1, 1, 0, 5'd8, ALU_SUB, 32'h11, 32'h9, 32'h9);
    // Load-use: lw $6 then or $7,$6,$0 stalls exactly once
    tick(); issue_lw6(); exp_x("lw_x", 1, 1, 1, 5'd6, ALU_ADD, 32'h100, 32'h4, 32'h0);
    tick(); set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("lu_s", 1'b1); exp_bub("lu_x");
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd6; bus.mem_val = 32'hCAFE;
    set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("lu2_s", 1'b0); exp_x("lu2_x", 1, 1, 0, 5'd7, ALU_OR, 32'hCAFE, 32'h0, 32'h0);
`else
    // ALU dependency on EX: two stall cycles until the producer passes WB
    tick(); set_id(ALU_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 32'h10, 32'h20, 5'd3, 1'b1, 1'b0);
    exp_s("add_s", 1'b0); exp_x("add_x", 1, 1, 0, 5'd3, ALU_ADD, 32'h10, 32'h20, 32'h20);
    tick(); bus.alu_s = 32'h7;
    set_id(ALU_SUB, 5'd3, 5'd5, 1'b1, 1'b1, 32'hDEAD, 32'h5, 5'd4, 1'b1, 1'b0);
    exp_s("exdep_s", 1'b1); exp_bub("exdep_x");
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd3; bus.mem_val = 32'h7;
    set_id(ALU_SUB, 5'd3, 5'd5, 1'b1, 1'b1, 32'hDEAD, 32'h5, 5'd4, 1'b1, 1'b0);
    exp_s("memdep_s", 1'b1); exp_bub("memdep_x");
    tick(); set_id(ALU_SUB, 5'd3, 5'd5, 1'b1, 1'b1, 32'h7, 32'h5, 5'd4, 1'b1, 1'b0);
    exp_s("dep_done_s", 1'b0); exp_x("dep_done_x", 1, 1, 0, 5'd4, ALU_SUB, 32'h7, 32'h5, 32'h5);
    // MEM-only dependency on rt, then the same rt unused
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd9; bus.mem_val = 32'h11;
    set_id(ALU_SUB, 5'd1, 5'd9, 1'b1, 1'b1, 32'h1, 32'h99, 5'd8, 1'b1, 1'b0);
    exp_s("rtdep_s", 1'b1); exp_bub("rtdep_x");
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd9; bus.mem_val = 32'h11;
    set_id(ALU_SUB, 5'd1, 5'd9, 1'b1, 1'b0, 32'h1, 32'h99, 5'd8, 1'b1, 1'b0);
    bus.id_aluimm = 1'b1; bus.id_imm = 32'h40;
    exp_s("rtunused_s", 1'b0); exp_x("rtunused_x", 1, 1, 0, 5'd8, ALU_SUB, 32'h1, 32'h40, 32'h99);
    // Load-use without forwarding: stalls while the load sits in EX and MEM
    tick(); issue_lw6(); exp_x("lw_x", 1, 1, 1, 5'd6, ALU_ADD, 32'h100, 32'h4, 32'h0);
    tick(); set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("lu_s", 1'b1); exp_bub("lu_x");
    tick(); bus.mem_wreg = 1'b1; bus.mem_wn = 5'd6; bus.mem_val = 32'hCAFE;
    set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("lu_mem_s", 1'b1); exp_bub("lu_mem_x");
    tick(); set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hCAFE, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("lu2_s", 1'b0); exp_x("lu2_x", 1, 1, 0, 5'd7, ALU_OR, 32'hCAFE, 32'h0, 32'h0);
`endif

    // Flush together with a load-use hazard
    tick(); issue_lw6(); exp_x("lw_b_x", 1, 1, 1, 5'd6, ALU_ADD, 32'h100, 32'h4, 32'h0);
    tick(); set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b1, 1'b0);
    bus.flush = 1'b1;
    exp_s("flush_s", 1'b0); exp_bub("flush_x");

    // Shift and $0: writing EX/MEM producers with wn=0 are never forwarded
    tick(); set_id(ALU_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 32'h3, 32'h4, 5'd0, 1'b1, 1'b0);
    exp_x("wn0_x", 1, 1, 0, 5'd0, ALU_ADD, 32'h3, 32'h4, 32'h4);
    tick(); bus.alu_s = 32'hFFFF_FFFF; bus.mem_wreg = 1'b1; bus.mem_wn = 5'd0; bus.mem_val = 32'hEEEE;
    set_id(ALU_SLL, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0, 32'h1, 5'd2, 1'b1, 1'b0);
    bus.id_shift = 1'b1; bus.id_sa = 5'd5;
    exp_s("sll_s", 1'b0); exp_x("sll_x", 1, 1, 0, 5'd2, ALU_SLL, 32'h5, 32'h1, 32'h1);

    // Reset in the middle of a load-use stall
    tick(); issue_lw6(); exp_x("lw_c_x", 1, 1, 1, 5'd6, ALU_ADD, 32'h100, 32'h4, 32'h0);
    tick(); set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hCAFE, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("pre_rst_s", 1'b1); exp_bub("pre_rst_x");
    tick(); reset = 1'b1;
    set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hCAFE, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("rst_mid_s", 1'b0); exp_bub("rst_mid_x");
    tick(); reset = 1'b0;
    set_id(ALU_OR, 5'd6, 5'd0, 1'b1, 1'b1, 32'hCAFE, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_s("post_rst_s", 1'b0); exp_x("post_rst_x", 1, 1, 0, 5'd7, ALU_OR, 32'hCAFE, 32'h0, 32'h0);

    tick(); exp_s("end_s", 1'b0); exp_bub("end_x");
    repeat (3) @(posedge clock);
    #1;

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline boundary for the five-stage pipelined computer. Each cycle it accepts one decoded instruction from ID and selects ALU operands, forwarding results from later stages. It registers `a`, `b` and `aluc` together with writeback control into the EX stage, and drives the ALU from those registers. It also detects load-use hazards and raises a stall back to IF/ID.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RN`, 5: register number width.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high; clears all EX registers.
- `id_valid`  in  1: ID holds a real instruction.
- `id_aluc`  in  4: ALU opcode, in the team's ALU encoding.
- `id_rs`, `id_rt`  in  RN: source register numbers.
- `id_use_rs`, `id_use_rt`  in  1: the instruction reads that source.
- `id_qa`, `id_qb`  in  XLEN: register-file read data. The register file bypasses WB internally.
- `id_imm`  in  XLEN: already-extended immediate.
- `id_sa`  in  5: shift amount.
- `id_shift`  in  1: select `sa` as operand `a`.
- `id_aluimm`  in  1: select `imm` as operand `b`.
- `id_wreg`, `id_m2reg`  in  1: writes a register / result comes from memory.
- `id_wn`  in  RN: destination register.
- `flush`  in  1: squash the ID instruction (taken branch/jump).
- `alu_s`  in  XLEN: ALU result for the instruction currently in EX.
- `mem_wreg`  in  1, `mem_wn`  in  RN, `mem_val`  in  XLEN: MEM-stage writeback candidate. This is the ALU result, or load data once available.
- `ex_valid`, `ex_wreg`, `ex_m2reg`  out  1; `ex_wn`  out  RN.
- `ex_a`, `ex_b`  out  XLEN; `ex_aluc`  out  4: ALU operands.
- `ex_st_data`  out  XLEN: forwarded `rt` value for stores.
- `stall`  out  1: hold PC and the IF/ID register this cycle.

## Operation
- **Forwarding source** for each used source `r` with `r != 0`:
  - First choice is EX: `ex_valid & ex_wreg & ~ex_m2reg & ex_wn == r` → `alu_s`.
  - Otherwise MEM: `mem_wreg & mem_wn == r` → `mem_val`.
  - Otherwise the register-file value.
  - Register 0 is never forwarded; it reads as `id_qa`/`id_qb` (0).
- **Operand select**:
  - `ex_a` = `id_shift` ? zero-extended `id_sa` : forwarded `rs`.
  - `ex_b` = `id_aluimm` ? `id_imm` : forwarded `rt`.
  - `ex_st_data` = forwarded `rt`, always.
- **Load-use hazard**: `id_valid & ex_valid & ex_wreg & ex_m2reg & ex_wn != 0`, and `ex_wn` matches a used source → `stall` = 1.
  - A bubble is loaded: `ex_valid`, `ex_wreg`, `ex_m2reg` = 0; `ex_aluc` = 0; `ex_a`, `ex_b` = 0.
  - The ID instruction is re-presented next cycle and then forwards from MEM.
- **Flush**: has priority over everything.
  - A bubble is loaded and `stall` is forced to 0.
- **Simultaneous events**: `flush` together with a hazard → bubble, `stall` = 0. `reset` overrides `flush` and `stall`.
- `id_valid` = 0 → bubble, `stall` = 0.
- **Widths**: all selects are pure muxes; no arithmetic in this block.

## Timing
- All `ex_*` outputs are registered and update on the rising `clock` edge.
- Issue latency is 1 cycle, ID to EX.
- `stall` is combinational from the `id_*` inputs and the current `ex_*` registers, and is valid in the same cycle.
- **Reset values**: `ex_valid`, `ex_wreg`, `ex_m2reg` = 0; `ex_wn` = 0; `ex_a`, `ex_b`, `ex_st_data` = 0; `ex_aluc` = 4'b0000. `stall` = 0 after reset because EX is empty.
- **Load-use** costs exactly one stall cycle.
- **Reset mid-stall**: the next cycle shows `stall` = 0 and an empty EX; the instruction is re-fetched by IF/ID reset.

## Configuration
- `EX_ISSUE_FWD_EN` defined: forwarding as described above.
- `EX_ISSUE_FWD_EN` undefined:
  - No forwarding paths; operands always come from `id_qa`/`id_qb`.
  - `stall` asserts whenever a used nonzero source matches a valid writing EX or MEM destination, whether ALU or load.
  - Bubbles are inserted until the producer passes WB.
  - `alu_s` and `mem_val` are unused.

## Structure
- **Shared package `pipe_pkg`**:
  - `XLEN` and `RN` constants.
  - ALU opcode constants `ALU_ADD` 4'b0000, `ALU_SUB` 4'b0100, `ALU_AND` 4'b0001, `ALU_OR` 4'b0101, `ALU_XOR` 4'b0010, `ALU_LUI` 4'b0110, `ALU_SLL` 4'b0011, `ALU_SRL` 4'b0111, `ALU_SRA` 4'b1111, `ALU_SLT` 4'b1011.
  - A packed `ex_ctrl_t` holding `valid`, `wreg`, `m2reg`, `wn`.
- **Sub-module `fwd_mux`**: one per source, instantiated twice. It takes `r`, `use`, the register-file value and both forwarding candidates, and returns the selected value plus a load-hit flag.

## Test plan
- **Reset**: assert `reset` 2 cycles with `id_valid` = 1 → all `ex_*` = 0 and `stall` = 0 on the first cycle after release.
- **EX forward**: `add $3,$1,$2` in EX with `alu_s` = 0x0000_0007, then `sub $4,$3,$5` with `id_qa` = 0xDEAD → `ex_a` = 7 and `ex_aluc` = 4'b0100.
- **MEM forward and priority**: `mem_wn` = 3 with `mem_val` = 0x11, EX `ex_wn` = 3 with `alu_s` = 0x22 → `ex_a` = 0x22. Remove the EX match → `ex_a` = 0x11.
- **Load-use**: `lw $6` in EX, then `or $7,$6,$0` → `stall` = 1 for one cycle and a bubble (`ex_valid` = 0). Next cycle: `stall` = 0 and `ex_a` = `mem_val`.
- **Flush with hazard**: the load-use condition together with `flush` = 1 → `stall` = 0 and bubble.
- **Shift and $0**:
  - `sll $2,$0,5` with `id_qb` = 0x1 and `ex_wn` = 0 marked writing → `ex_a` = 5 and `ex_b` = 0x1, with no forward taken from `$0`.
  - With `EX_ISSUE_FWD_EN` undefined, an ALU dependency on EX → 2 stall cycles.
